// File: rtl/seq_scan_arbiter_pkg.sv
// seq_scan_arbiter_pkg: shared state encodings and word width for the scan arbiter
package seq_scan_arbiter_pkg;
  localparam int WORD_W = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;
  typedef enum logic [1:0] {RESET, GOT1, GOT10, GOT101} det_state_t;
endpackage

// File: rtl/seq_scan_arbiter_det.sv
// seq101_det: Moore overlapping "101" detector, z decoded from registered state
module seq101_det
  import seq_scan_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic z
);
  det_state_t st;
  always_ff @(posedge clk)
    if (rst) st <= RESET;
    else
      case (st)
        RESET:   st <= x ? GOT1 : RESET;
        GOT1:    st <= x ? GOT1 : GOT10;
        GOT10:   st <= x ? GOT101 : RESET;
        default: st <= x ? GOT1 : GOT10;
      endcase
  assign z = st == GOT101;
endmodule

// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter: round-robin grant of two word sources, serial "101" count per word
module seq_scan_arbiter
  import seq_scan_arbiter_pkg::*;
#(
  parameter int WORD_W = seq_scan_arbiter_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [WORD_W-1:0] req_data0,
  input  logic [WORD_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic              res_valid,
  output logic              res_id,
  output logic [3:0]        res_count,
  output logic [7:0]        total_matches,
  output logic              busy
);
  state_t            state;
  logic              last_grant, cur_id, g, hs, z;
  logic [WORD_W-1:0] sr;
  logic [3:0]        bit_cnt, match_cnt, final_cnt;
  logic [8:0]        sum;
  assign g         = &req_valid ? ~last_grant : req_valid[1];
  assign req_ready = (state == IDLE && !rst && |req_valid) ? (g ? 2'b10 : 2'b01) : 2'b00;
  assign hs        = |req_ready;
  assign busy      = state != IDLE;
  assign final_cnt = match_cnt + 4'(z);
  assign sum       = {1'b0, total_matches} + {5'd0, final_cnt};
  // Detector restarts on every handshake so no match spans two words
  seq101_det u_det (
    .clk (clk),
    .rst (rst | hs),
    .x   (sr[WORD_W-1]),
    .z   (z)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      cur_id        <= 1'b0;
      sr            <= '0;
      bit_cnt       <= '0;
      match_cnt     <= '0;
      res_valid     <= 1'b0;
      res_id        <= 1'b0;
      res_count     <= '0;
      total_matches <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE:
          if (hs) begin
            sr         <= g ? req_data1 : req_data0;
            cur_id     <= g;
            last_grant <= g;
            bit_cnt    <= '0;
            match_cnt  <= '0;
            state      <= SHIFT;
          end
        SHIFT: begin
          sr      <= sr << 1;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt != 4'd0 && z) match_cnt <= match_cnt + 4'd1;
          if (bit_cnt == 4'(WORD_W - 1)) state <= DRAIN;
        end
        default: begin
          res_valid     <= 1'b1;
          res_id        <= cur_id;
          res_count     <= final_cnt;
          total_matches <= sum[8] ? 8'hFF : sum[7:0];
          state         <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_seq_scan_arbiter.sv
// tb_seq_scan_arbiter: directed checks of grant, timing, counting, saturation and abort
module tb_seq_scan_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [7:0] req_data0 = 8'h00, req_data1 = 8'h00;
  logic [1:0] req_ready;
  logic       res_valid, res_id, busy;
  logic [3:0] res_count;
  logic [7:0] total_matches;
  int         n_run = 0, n_fail = 0;
  int         tot;

  seq_scan_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data0     (req_data0),
    .req_data1     (req_data1),
    .req_ready     (req_ready),
    .res_valid     (res_valid),
    .res_id        (res_id),
    .res_count     (res_count),
    .total_matches (total_matches),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_run++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Called in an IDLE cycle; returns in the result cycle T+10
  task automatic word(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                      input bit drop, input logic [1:0] er, input logic eid,
                      input logic [3:0] ec, input logic [7:0] et);
    req_valid = v;
    req_data0 = a;
    req_data1 = b;
    #1;
    chk("grant", 32'(req_ready), 32'(er));
    tick();
    if (drop) req_valid = 2'b00;
    chk("busy_shift", 32'(busy), 1);
    repeat (4) tick();
    chk("ready_shift", 32'(req_ready), 0);
    chk("no_early_res", 32'(res_valid), 0);
    repeat (4) tick();
    chk("drain_busy", 32'(busy), 1);
    chk("drain_no_res", 32'(res_valid), 0);
    tick();
    chk("res_valid", 32'(res_valid), 1);
    chk("res_id", 32'(res_id), 32'(eid));
    chk("res_count", 32'(res_count), 32'(ec));
    chk("total", 32'(total_matches), 32'(et));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b01;
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_id", 32'(res_id), 0);
    chk("rst_res_count", 32'(res_count), 0);
    chk("rst_total", 32'(total_matches), 0);
    rst = 1'b0;
    word(2'b01, 8'hA5, 8'h00, 1, 2'b01, 0, 4'd2, 8'd2);
    tick();
    chk("res_pulse", 32'(res_valid), 0);
    chk("res_count_hold", 32'(res_count), 2);
    chk("res_id_hold", 32'(res_id), 0);
    chk("total_hold", 32'(total_matches), 2);
    chk("no_extra_grant", 32'(busy), 0);

    do_reset();
    word(2'b11, 8'hAA, 8'h00, 0, 2'b01, 0, 4'd3, 8'd3);
    word(2'b11, 8'hAA, 8'h00, 0, 2'b10, 1, 4'd0, 8'd3);
    word(2'b11, 8'hAA, 8'h00, 0, 2'b01, 0, 4'd3, 8'd6);
    word(2'b11, 8'hAA, 8'h00, 0, 2'b10, 1, 4'd0, 8'd6);

    do_reset();
    word(2'b10, 8'h00, 8'hFF, 0, 2'b10, 1, 4'd0, 8'd0);
    word(2'b10, 8'h00, 8'h15, 0, 2'b10, 1, 4'd2, 8'd2);
    word(2'b10, 8'h00, 8'hFF, 0, 2'b10, 1, 4'd0, 8'd2);
    word(2'b10, 8'h00, 8'h40, 1, 2'b10, 1, 4'd0, 8'd2);

    // Abort a word mid-scan
    tick();
    req_valid = 2'b01;
    req_data0 = 8'hAA;
    #1;
    chk("abort_grant", 32'(req_ready), 1);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("ready_in_rst", 32'(req_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(req_ready), 1);
    chk("abort_total", 32'(total_matches), 0);
    chk("abort_busy", 32'(busy), 0);
    req_valid = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_no_res", 32'(res_valid), 0);
    end

    do_reset();
    tot = 0;
    for (int i = 0; i < 90; i++) begin
      tot = (tot + 3 > 255) ? 255 : tot + 3;
      word(2'b01, 8'hAA, 8'h00, 0, 2'b01, 0, 4'd3, 8'(tot));
    end
    req_valid = 2'b00;
    tick();
    chk("sat_final", 32'(total_matches), 255);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seq_scan_arbiter.md
SEQ_SCAN_ARBITER -- requirements
Module: seq_scan_arbiter

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8, the bits per scanned word; only 8 is required to be supported.
REQ-002 The block SHALL have port clk  input  1  the system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-004 The block SHALL have port req_valid  input  2  per-requester word-valid flag; bit i belongs to requester i.
REQ-005 The block SHALL have port req_data0  input  8  requester 0 word; bit 7 is scanned first.
REQ-006 The block SHALL have port req_data1  input  8  requester 1 word; bit 7 is scanned first.
REQ-007 The block SHALL have port req_ready  output  2  per-requester accept flag, one-hot or zero.
REQ-008 The block SHALL have port res_valid  output  1  one-cycle result strobe.
REQ-009 The block SHALL have port res_id  output  1  the requester that owns the result.
REQ-010 The block SHALL have port res_count  output  4  the number of "101" matches in the word.
REQ-011 The block SHALL have port total_matches  output  8  saturating running total of res_count.
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DRAIN.
REQ-014 In IDLE with any req_valid high, the block SHALL grant one requester combinationally: req_ready[g]=1 in that same cycle; the handshake occurs when req_valid[g] and req_ready[g] are both high.
REQ-015 Arbitration SHALL be round-robin: if both requesters are valid, grant the one not granted last; if one is valid, grant it; last_grant SHALL update only on a handshake.
REQ-016 On handshake the block SHALL: capture req_data[g] into an 8-bit shift register; record g; clear bit_cnt and match_cnt; synchronously reset the detector; go to SHIFT.
REQ-017 In each SHIFT cycle the block SHALL: drive shift-register bit 7 into the detector x; shift left by one; increment bit_cnt.
REQ-018 After 8 SHIFT cycles the FSM SHALL go to DRAIN, which is one cycle long, and then return to IDLE.
REQ-019 In SHIFT cycles 2..8 and in the DRAIN cycle, the block SHALL increment match_cnt whenever the detector z is 1.
REQ-020 Matches SHALL overlap, e.g. 10101 counts 2; detector state SHALL NOT carry across words.
REQ-021 Timing: handshake at cycle T; SHIFT at T+1..T+8; DRAIN at T+9; res_valid=1 for exactly cycle T+10, with res_id and res_count valid in that cycle.
REQ-022 A new handshake SHALL be permitted in cycle T+10, giving a throughput of one word per 10 cycles.
REQ-023 req_ready SHALL be 0 in SHIFT and in DRAIN; req_valid and req_data SHALL be ignored outside IDLE.
REQ-024 total_matches SHALL add res_count in the res_valid cycle and SHALL saturate at 255 with no wrap.
REQ-025 res_id and res_count SHALL hold their values between strobes.

Reset
REQ-026 While rst is high, the FSM SHALL go to IDLE and the block SHALL hold: last_grant=1 (so requester 0 wins first), shift register=0, bit_cnt=0, match_cnt=0, res_valid=0, res_id=0, res_count=0, total_matches=0, busy=0, and the detector in its reset state.
REQ-027 A reset asserted in SHIFT or DRAIN SHALL abort the word: no res_valid SHALL follow and total_matches SHALL clear.
REQ-028 While rst is high, req_ready SHALL be 0.

Structure
REQ-029 A shared package SHALL hold: the FSM state encoding (IDLE, SHIFT, DRAIN), WORD_W, and the detector state encoding (RESET, GOT1, GOT10, GOT101).
REQ-030 The detector SHALL be one sub-module, seq101_det: a Moore overlapping "101" detector with ports clk, rst, x, z, where z is registered-state based.
REQ-031 The arbiter and serializer SHALL stay in seq_scan_arbiter.

Verification
REQ-032 Scenario: rst, then req_valid=01 with req_data0=0xA5 -> req_ready=01 at T; res_valid at T+10; res_id=0; res_count=2; total_matches=2.
REQ-033 Scenario: both requesters valid continuously, data0=0xAA, data1=0x00 -> grants alternate 0,1,0,1; res_count alternates 3,0; handshakes are exactly 10 cycles apart.
REQ-034 Scenario: requester 1 alone with 0xFF, then 0x15 -> res_count=0, then 2; no cross-word match.
REQ-035 Scenario: rst pulsed at T+5 during a word -> no res_valid; req_ready available again the cycle after rst falls.
REQ-036 Scenario: 90 words of 0xAA -> total_matches saturates at 255 and stays there.
REQ-037 Scenario: req_valid deasserted while in SHIFT -> the result is still produced; no extra grant occurs.
